// File: rtl/aes_key_expand_pkg.sv
// Shared AES key-schedule types, per-mode constants and round-constant table.
// Imported by the key expander and the S-box.
package aes_key_expand_pkg;

    typedef logic ulogic_t;
    typedef logic [7:0] ubyte_t;
    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10
    } key_mode_t;

    localparam int MAX_WORDS = 60;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam ubyte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [3:0] nk_of(key_mode_t m);
        case (m)
            KEY_192: nk_of = NK_192;
            KEY_256: nk_of = NK_256;
            default: nk_of = NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_mode_t m);
        case (m)
            KEY_192: nr_of = NR_192;
            KEY_256: nr_of = NR_256;
            default: nr_of = NR_128;
        endcase
    endfunction

    function automatic ubyte_t rcon_of(logic [3:0] g);
        rcon_of = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            if (g == 4'(k)) rcon_of = RCON[k];
        end
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational lookup.
// Shared by the key schedule (SubWord) and the cipher SubBytes stage.
module aes_sbox
    import aes_key_expand_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] sub
);

    localparam ubyte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = SBOX[val];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key schedule, one word per clock, registered round-key port.
// Optional AES_RK_READ_GUARD_EN zeroes o_rk whenever the schedule is not ready.
module aes_key_expand #(
    parameter int MAX_WORDS = aes_key_expand_pkg::MAX_WORDS,
    parameter int RK_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 resetH,
    input  logic                 i_start,
    input  logic [1:0]           i_key_mode,
    input  logic [255:0]         i_key,
    output logic                 o_key_ready,
    output logic [3:0]           o_nr,
    input  logic [RK_ADDR_W-1:0] i_rk_addr,
    output logic [127:0]         o_rk
);

    import aes_key_expand_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    state_t    state;
    state_t    state_nxt;
    logic      ready_nxt;
    logic      accept;
    key_mode_t mode;
    logic [255:0] key_reg;
    logic [5:0] idx;
    logic [2:0] pos;
    logic [3:0] grp;
    logic [3:0] nk;
    logic [3:0] nr;
    logic       last;

    aes_word_t store [MAX_WORDS];
    aes_word_t w_prev;
    aes_word_t w_back;
    aes_word_t sel;
    aes_word_t sub;
    aes_word_t temp;
    aes_word_t new_word;

    assign nk     = nk_of(mode);
    assign nr     = nr_of(mode);
    assign last   = (idx == {nr, 2'b11});
    assign w_prev = store[idx - 6'd1];
    assign w_back = store[idx - {2'b00, nk}];

    // First word of each group is rotated before substitution
    assign sel = (pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .val(sel[8*b +: 8]),
            .sub(sub[8*b +: 8])
        );
    end

    always_comb begin
        temp = w_prev;
        if (pos == 3'd0) begin
            temp = sub ^ {rcon_of(grp), 24'h0};
        end else if (nk == NK_256 && pos == 3'd4) begin
            temp = sub;
        end
        new_word = w_back ^ temp;
    end

    always_comb begin
        state_nxt = state;
        ready_nxt = o_key_ready;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start && i_key_mode != 2'b11) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                    ready_nxt = 1'b0;
                end
            end
            LOAD: state_nxt = EXPAND;
            EXPAND: begin
                if (last) begin
                    state_nxt = DONE;
                    ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetH) begin
            state       <= IDLE;
            o_key_ready <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_key_ready <= ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (resetH) begin
            mode    <= KEY_128;
            key_reg <= '0;
            idx     <= '0;
            pos     <= '0;
            grp     <= '0;
            o_nr    <= '0;
        end else if (accept) begin
            mode    <= key_mode_t'(i_key_mode);
            key_reg <= i_key;
        end else if (state == LOAD) begin
            idx  <= {2'b00, nk};
            pos  <= '0;
            grp  <= 4'd1;
            o_nr <= nr;
        end else if (state == EXPAND) begin
            idx <= idx + 6'd1;
            if ({1'b0, pos} == nk - 4'd1) begin
                pos <= '0;
                grp <= grp + 4'd1;
            end else begin
                pos <= pos + 3'd1;
            end
        end
    end

    // Word store is deliberately left unreset
    always_ff @(posedge clk) begin
        if (!resetH) begin
            if (state == LOAD) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(nk)) store[k] <= key_reg[255-32*k -: 32];
                end
            end else if (state == EXPAND) begin
                store[idx] <= new_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetH) begin
            o_rk <= '0;
        end else if (4'(i_rk_addr) > o_nr) begin
            o_rk <= '0;
`ifdef AES_RK_READ_GUARD_EN
        end else if (!ready_nxt) begin
            o_rk <= '0;
`endif
        end else begin
            o_rk <= {store[{i_rk_addr, 2'd0}], store[{i_rk_addr, 2'd1}],
                     store[{i_rk_addr, 2'd2}], store[{i_rk_addr, 2'd3}]};
        end
    end

endmodule
